// File: rtl/hubris_wb_pkg.sv
`default_nettype none
// hubris_wb_pkg: shared load-size encodings and byte-lane masks for the writeback stage.
package hubris_wb_pkg;

  localparam logic [1:0] LS_BYTE = 2'd0;
  localparam logic [1:0] LS_HALF = 2'd1;
  localparam logic [1:0] LS_WORD = 2'd2;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/wb_load_fifo.sv
`default_nettype none
// wb_load_fifo: synchronous FIFO holding formatted load writebacks {rd, data, mask}.
module wb_load_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// writeback_stage: arbitrates the register-file write port between ALU results (priority)
// and formatted, FIFO-buffered load returns.
module writeback_stage
  import hubris_wb_pkg::*;
#(
  parameter int REG_NUMBER                = 32,
  parameter int REG_WIDTH                 = 32,
  parameter int REG_ADDR_WIDTH            = $clog2(REG_NUMBER),
  parameter int REG_BYTE_WRITE_MASK_WIDTH = REG_WIDTH / 8,
  parameter int LOAD_FIFO_DEPTH           = 2,
  localparam int CNT_W = $clog2(LOAD_FIFO_DEPTH) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0]            alu_rd,
  input  logic [REG_WIDTH-1:0]                 alu_data,
  input  logic                                 load_valid,
  output logic                                 load_ready,
  input  logic [REG_ADDR_WIDTH-1:0]            load_rd,
  input  logic [REG_WIDTH-1:0]                 load_data,
  input  logic [1:0]                           load_size,
  input  logic                                 load_unsigned,
  input  logic                                 load_merge,
  input  logic [1:0]                           load_offset,
  output logic                                 stall_req,
  output logic [CNT_W-1:0]                     fifo_count,
  output logic                                 write_enable,
  output logic [REG_ADDR_WIDTH-1:0]            write_reg_addr,
  output logic [REG_WIDTH-1:0]                 write_data,
  output logic [REG_BYTE_WRITE_MASK_WIDTH-1:0] write_byte_mask
);

  localparam int MW = REG_BYTE_WRITE_MASK_WIDTH;
  localparam int EW = REG_ADDR_WIDTH + REG_WIDTH + MW;

  logic [7:0]                byte_sel;
  logic [15:0]               half_sel;
  logic [REG_WIDTH-1:0]      fmt_data;
  logic [MW-1:0]             fmt_mask;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic [EW-1:0]             head;
  logic [REG_ADDR_WIDTH-1:0] head_rd;
  logic [REG_WIDTH-1:0]      head_data;
  logic [MW-1:0]             head_mask;

  assign byte_sel = 8'(load_data >> {load_offset, 3'b000});
  assign half_sel = 16'(load_data >> {load_offset[1], 4'b0000});

  always_comb begin
    fmt_data = load_data;
    fmt_mask = '1;
    case (load_size)
      LS_BYTE: begin
        if (load_merge) begin
          fmt_data = {{(REG_WIDTH-8){1'b0}}, byte_sel};
          fmt_mask = MW'(MASK_B);
        end else if (load_unsigned) begin
          fmt_data = {{(REG_WIDTH-8){1'b0}}, byte_sel};
        end else begin
          fmt_data = {{(REG_WIDTH-8){byte_sel[7]}}, byte_sel};
        end
      end
      LS_HALF: begin
        if (load_merge) begin
          fmt_data = {{(REG_WIDTH-16){1'b0}}, half_sel};
          fmt_mask = MW'(MASK_H);
        end else if (load_unsigned) begin
          fmt_data = {{(REG_WIDTH-16){1'b0}}, half_sel};
        end else begin
          fmt_data = {{(REG_WIDTH-16){half_sel[15]}}, half_sel};
        end
      end
      default: begin
        fmt_data = load_data;
        fmt_mask = '1;
      end
    endcase
  end

  // Readiness deliberately ignores a same-cycle pop, so a full FIFO never sees a push.
  assign load_ready = rst_n && !fifo_full;
  assign stall_req  = fifo_full;
  assign push       = load_valid && load_ready && (load_rd != '0);
  assign pop        = !alu_valid && !fifo_empty;

  wb_load_fifo #(
    .DEPTH (LOAD_FIFO_DEPTH),
    .WIDTH (EW)
  ) u_load_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({load_rd, fmt_data, fmt_mask}),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_rd, head_data, head_mask} = head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_enable    <= 1'b0;
      write_reg_addr  <= '0;
      write_data      <= '0;
      write_byte_mask <= '0;
    end else begin
      write_enable <= 1'b0;
      if (alu_valid) begin
        if (alu_rd != '0) begin
          write_enable    <= 1'b1;
          write_reg_addr  <= alu_rd;
          write_data      <= alu_data;
          write_byte_mask <= '1;
        end
      end else if (!fifo_empty) begin
        if (head_rd != '0) begin
          write_enable    <= 1'b1;
          write_reg_addr  <= head_rd;
          write_data      <= head_data;
          write_byte_mask <= head_mask;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// tb_writeback_stage: directed vectors with hand-computed expectations for writeback_stage.
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  load_rd;
  logic [31:0] load_data;
  logic [1:0]  load_size;
  logic        load_unsigned;
  logic        load_merge;
  logic [1:0]  load_offset;
  logic        stall_req;
  logic [1:0]  fifo_count;
  logic        write_enable;
  logic [4:0]  write_reg_addr;
  logic [31:0] write_data;
  logic [3:0]  write_byte_mask;

  int checks = 0;
  int errors = 0;

  writeback_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alu_valid       (alu_valid),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_rd         (load_rd),
    .load_data       (load_data),
    .load_size       (load_size),
    .load_unsigned   (load_unsigned),
    .load_merge      (load_merge),
    .load_offset     (load_offset),
    .stall_req       (stall_req),
    .fifo_count      (fifo_count),
    .write_enable    (write_enable),
    .write_reg_addr  (write_reg_addr),
    .write_data      (write_data),
    .write_byte_mask (write_byte_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic v, input logic [4:0] rd, input logic [31:0] d,
                          input logic [1:0] sz, input logic u, input logic m, input logic [1:0] off);
    load_valid    = v;
    load_rd       = rd;
    load_data     = d;
    load_size     = sz;
    load_unsigned = u;
    load_merge    = m;
    load_offset   = off;
  endtask

  task automatic fmt_case(input string tag, input logic [1:0] sz, input logic u, input logic m,
                          input logic [1:0] off, input logic [31:0] exp_d, input logic [3:0] exp_m);
    set_load(1'b1, 5'd9, 32'h80FF7F01, sz, u, m, off);
    step();
    load_valid = 1'b0;
    step();
    check({tag, "_we"}, 64'(write_enable), 64'(1'b1));
    check({tag, "_addr"}, 64'(write_reg_addr), 64'(5'd9));
    check({tag, "_data"}, 64'(write_data), 64'(exp_d));
    check({tag, "_mask"}, 64'(write_byte_mask), 64'(exp_m));
  endtask

  initial begin
    rst_n     = 1'b0;
    alu_valid = 1'b0;
    alu_rd    = 5'd0;
    alu_data  = 32'h0;
    set_load(1'b1, 5'd3, 32'h12345678, 2'd2, 1'b0, 1'b0, 2'd0);

    // Reset held for two edges with a load offered
    step();
    step();
    check("rst_we", 64'(write_enable), 64'(0));
    check("rst_addr", 64'(write_reg_addr), 64'(0));
    check("rst_data", 64'(write_data), 64'(0));
    check("rst_mask", 64'(write_byte_mask), 64'(0));
    check("rst_ready", 64'(load_ready), 64'(0));
    check("rst_count", 64'(fifo_count), 64'(0));
    check("rst_stall", 64'(stall_req), 64'(0));
    rst_n      = 1'b1;
    load_valid = 1'b0;
    #1;
    check("rel_ready", 64'(load_ready), 64'(1));
    step();
    check("rel_count", 64'(fifo_count), 64'(0));
    check("rel_we", 64'(write_enable), 64'(0));

    // ALU path
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEADBEEF;
    step();
    check("alu_we", 64'(write_enable), 64'(1));
    check("alu_addr", 64'(write_reg_addr), 64'(5));
    check("alu_data", 64'(write_data), 64'(32'hDEADBEEF));
    check("alu_mask", 64'(write_byte_mask), 64'(4'hF));
    alu_rd   = 5'd0;
    alu_data = 32'h11112222;
    step();
    check("alu_r0_we", 64'(write_enable), 64'(0));
    check("alu_r0_hold", 64'(write_data), 64'(32'hDEADBEEF));
    alu_valid = 1'b0;
    step();

    // Load formatting on 32'h80FF7F01
    fmt_case("lb_s", 2'd0, 1'b0, 1'b0, 2'd3, 32'hFFFFFF80, 4'hF);
    fmt_case("lb_u", 2'd0, 1'b1, 1'b0, 2'd3, 32'h00000080, 4'hF);
    fmt_case("lh_s", 2'd1, 1'b0, 1'b0, 2'd2, 32'hFFFF80FF, 4'hF);
    fmt_case("lb_m", 2'd0, 1'b0, 1'b1, 2'd1, 32'h0000007F, 4'h1);
    fmt_case("lh_m", 2'd1, 1'b0, 1'b1, 2'd0, 32'h00007F01, 4'h3);
    fmt_case("lw",   2'd3, 1'b0, 1'b0, 2'd1, 32'h80FF7F01, 4'hF);

    // Contention: ALU holds the port for 4 cycles while 3 loads arrive
    alu_valid = 1'b1;
    alu_rd    = 5'd1;
    alu_data  = 32'hA0A0A0A0;
    set_load(1'b1, 5'd10, 32'h1111000A, 2'd2, 1'b0, 1'b0, 2'd0);
    step();
    check("ct_alu_addr", 64'(write_reg_addr), 64'(1));
    check("ct_cnt1", 64'(fifo_count), 64'(1));
    set_load(1'b1, 5'd11, 32'h1111000B, 2'd2, 1'b0, 1'b0, 2'd0);
    step();
    check("ct_cnt2", 64'(fifo_count), 64'(2));
    check("ct_ready0", 64'(load_ready), 64'(0));
    check("ct_stall", 64'(stall_req), 64'(1));
    set_load(1'b1, 5'd12, 32'h1111000C, 2'd2, 1'b0, 1'b0, 2'd0);
    step();
    check("ct_held_cnt", 64'(fifo_count), 64'(2));
    check("ct_alu_win", 64'(write_data), 64'(32'hA0A0A0A0));
    step();
    alu_valid = 1'b0;
    step();
    check("ct_w1_we", 64'(write_enable), 64'(1));
    check("ct_w1_addr", 64'(write_reg_addr), 64'(10));
    check("ct_w1_data", 64'(write_data), 64'(32'h1111000A));
    step();
    check("ct_w2_addr", 64'(write_reg_addr), 64'(11));
    check("ct_w2_data", 64'(write_data), 64'(32'h1111000B));
    check("ct_w2_cnt", 64'(fifo_count), 64'(1));
    load_valid = 1'b0;
    step();
    check("ct_w3_we", 64'(write_enable), 64'(1));
    check("ct_w3_addr", 64'(write_reg_addr), 64'(12));
    check("ct_w3_data", 64'(write_data), 64'(32'h1111000C));
    step();
    check("ct_idle_we", 64'(write_enable), 64'(0));
    check("ct_idle_cnt", 64'(fifo_count), 64'(0));

    // Simultaneous push/pop with one entry buffered
    alu_valid = 1'b1;
    alu_rd    = 5'd2;
    set_load(1'b1, 5'd7, 32'h00000707, 2'd2, 1'b0, 1'b0, 2'd0);
    step();
    check("pp_cnt_pre", 64'(fifo_count), 64'(1));
    alu_valid = 1'b0;
    set_load(1'b1, 5'd8, 32'h00000808, 2'd2, 1'b0, 1'b0, 2'd0);
    step();
    check("pp_cnt", 64'(fifo_count), 64'(1));
    check("pp_head_addr", 64'(write_reg_addr), 64'(7));
    check("pp_head_data", 64'(write_data), 64'(32'h00000707));
    load_valid = 1'b0;
    step();
    check("pp_next_addr", 64'(write_reg_addr), 64'(8));
    step();

    // Ten back-to-back loads to exercise pointer wrap
    for (int i = 0; i < 12; i++) begin
      if (i < 10)
        set_load(1'b1, 5'(16 + i), 32'hC0DE0000 + 32'(i), 2'd2, 1'b0, 1'b0, 2'd0);
      else
        load_valid = 1'b0;
      step();
      if (i >= 1 && i <= 10) begin
        check($sformatf("wrap%0d_we", i - 1), 64'(write_enable), 64'(1));
        check($sformatf("wrap%0d_addr", i - 1), 64'(write_reg_addr), 64'(16 + i - 1));
        check($sformatf("wrap%0d_data", i - 1), 64'(write_data), 64'(32'hC0DE0000 + 32'(i - 1)));
      end
    end
    check("wrap_cnt", 64'(fifo_count), 64'(0));
    check("wrap_idle_we", 64'(write_enable), 64'(0));

    // Load to r0 is consumed and dropped
    set_load(1'b1, 5'd0, 32'hFFFFFFFF, 2'd2, 1'b0, 1'b0, 2'd0);
    #1;
    check("r0_ready", 64'(load_ready), 64'(1));
    step();
    check("r0_cnt", 64'(fifo_count), 64'(0));
    check("r0_ready_after", 64'(load_ready), 64'(1));
    load_valid = 1'b0;
    step();
    check("r0_we", 64'(write_enable), 64'(0));
    check("r0_hold_data", 64'(write_data), 64'(32'hC0DE0009));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
